// File: rtl/pc_stage_controller_pkg.sv
// Shared definitions for the multi-cycle PC sequencer.
//   stage_e   : sequencer stage encodings as seen on the stage output
//   NOP_INSTR : canonical NOP (addi x0,x0,0) loaded into the instruction register on reset
//   branch_e  : branch codes produced by gen_branch_signal
//   clear_lsb : forces bit 0 low (JALR target semantics)
package pc_stage_controller_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } stage_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    BEQ       = 4'd0,
    BNE       = 4'd1,
    BLT       = 4'd2,
    BGE       = 4'd3,
    BLTU      = 4'd4,
    BGEU      = 4'd5,
    BJAL      = 4'd6,
    BJALR     = 4'd7,
    NOTBRANCH = 4'd8
  } branch_e;

  function automatic logic [31:0] clear_lsb(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_stage_controller.sv
// Multi-cycle control sequencer. Owns the architectural PC and steps each
// instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   hold                : freezes state machine and all registers
//   imem_req/addr       : fetch request and address (address is always pc)
//   imem_valid/rdata    : fetch response, only honoured in FETCH
//   instr               : latched instruction register
//   dmem_access         : load/store flag, sampled in EXECUTE
//   dmem_done           : data access complete, honoured in MEM
//   branch_signal/target: branch decision and target, sampled in EXECUTE
//   pc, pc_plus4        : current PC and its sequential successor
//   stage               : current stage encoding
//   rf_we_en            : one-cycle register-file write qualifier
//   misalign_trap       : one-cycle pulse on a misaligned taken target
//   instret             : retired instruction count
module pc_stage_controller
  import pc_stage_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dmem_access,
  input  logic        dmem_done,
  input  logic        branch_signal,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [2:0]  stage,
  output logic        rf_we_en,
  output logic        misalign_trap,
  output logic [31:0] instret
);

  stage_e      r_state;
  stage_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_next_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_trap_pending;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign imem_addr     = r_pc;
  assign instr         = r_instr;
  assign instret       = r_instret;
  assign stage         = r_state;
  assign imem_req      = (r_state == FETCH) && !hold;
  assign rf_we_en      = (r_state == WRITEBACK) && !hold && !r_trap_pending;
  assign misalign_trap = (r_state == WRITEBACK) && !hold &&  r_trap_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!hold) begin
      case (r_state)
        FETCH:     if (imem_valid) w_state_nxt = DECODE;
        DECODE:    w_state_nxt = EXECUTE;
        EXECUTE:   w_state_nxt = dmem_access ? MEM : WRITEBACK;
        MEM:       if (dmem_done) w_state_nxt = WRITEBACK;
        WRITEBACK: w_state_nxt = FETCH;
        default:   w_state_nxt = FETCH;
      endcase
    end
  end

  // Datapath registers; the next-PC select is kept inline with the stage it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_next_pc      <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_instret      <= '0;
      r_trap_pending <= 1'b0;
    end else if (!hold) begin
      case (r_state)
        FETCH: begin
          if (imem_valid) r_instr <= imem_rdata;
        end
        EXECUTE: begin
          if (branch_signal) begin
            r_next_pc <= clear_lsb(branch_target);
            // bit 1 survives the JALR bit-0 clear, so it alone flags a non-word target
            if (branch_target[1]) r_trap_pending <= 1'b1;
          end else begin
            r_next_pc <= w_pc_plus4;
          end
        end
        WRITEBACK: begin
          r_pc           <= r_trap_pending ? TRAP_VEC : r_next_pc;
          if (!r_trap_pending) r_instret <= r_instret + 32'd1;
          r_trap_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stage_controller.sv
module tb_pc_stage_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        dmem_access = 1'b0;
  logic        dmem_done = 1'b0;
  logic        branch_signal = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  stage;
  logic        rf_we_en;
  logic        misalign_trap;
  logic [31:0] instret;

  pc_stage_controller #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr),
    .dmem_access(dmem_access), .dmem_done(dmem_done),
    .branch_signal(branch_signal), .branch_target(branch_target),
    .pc(pc), .pc_plus4(pc_plus4), .stage(stage),
    .rf_we_en(rf_we_en), .misalign_trap(misalign_trap), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int unsigned imem_wait;
    logic        br;
    logic [31:0] tgt;
    logic        dacc;
    int unsigned mem_cycles;
  } txn_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] instr;
    logic [15:0] cycles;
    logic [3:0]  we;
    logic [3:0]  trap;
    logic        tmo;
  } res_t;

  res_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic [31:0] m_instr;

  // Computes the expected retirement from the bench's own model, queues it,
  // then drives one instruction through the DUT and returns what it observed.
  task automatic issue(input txn_t t, output res_t o);
    res_t        e;
    logic        trap;
    int unsigned wcnt = 0;
    int unsigned mcnt = 0;
    bit          wb;
    bit          done = 0;
    trap      = t.br && t.tgt[1];
    e         = '0;
    e.pc      = trap ? TRAP_VEC : (t.br ? {t.tgt[31:1], 1'b0} : m_pc + 32'd4);
    e.instret = trap ? m_instret : m_instret + 32'd1;
    e.instr   = t.rdata;
    e.cycles  = 16'(4 + t.imem_wait + (t.dacc ? t.mem_cycles : 0));
    e.we      = trap ? 4'd0 : 4'd1;
    e.trap    = trap ? 4'd1 : 4'd0;
    sb_q.push_back(e);
    m_pc = e.pc; m_instret = e.instret; m_instr = t.rdata;

    o = '0;
    for (int c = 0; c < 200; c++) begin
      hold          = 1'b0;
      imem_valid    = 1'b1;
      imem_rdata    = $urandom;
      branch_signal = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      dmem_access   = 1'($urandom_range(0, 1));
      dmem_done     = 1'b1;
      case (stage)
        3'd0: begin
          imem_valid = (wcnt >= t.imem_wait);
          if (imem_valid) imem_rdata = t.rdata;
        end
        3'd2: begin
          branch_signal = t.br;
          branch_target = t.tgt;
          dmem_access   = t.dacc;
        end
        3'd3: dmem_done = (mcnt + 1 >= t.mem_cycles);
        default: ;
      endcase
      @(negedge clk);
      if (rf_we_en)      o.we   = o.we + 4'd1;
      if (misalign_trap) o.trap = o.trap + 4'd1;
      wb = (stage == 3'd4);
      if (stage == 3'd0) wcnt++;
      if (stage == 3'd3) mcnt++;
      @(posedge clk); #1;
      o.cycles = o.cycles + 16'd1;
      if (wb) begin done = 1; break; end
    end
    o.tmo     = !done;
    o.pc      = pc;
    o.instret = instret;
    o.instr   = instr;
    imem_valid = 1'b0; dmem_done = 1'b0; dmem_access = 1'b0; branch_signal = 1'b0;
  endtask

  task automatic test_reset();
    txn_t t;
    res_t o, e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
    n_cmp++; if (stage !== 3'd0) begin n_bad++; $display("FAIL reset_stage got %0d exp 0", stage); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_imem_req got %b exp 1", imem_req); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL reset_instret got %0d exp 0", instret); end
    n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
    n_cmp++; if ({rf_we_en, misalign_trap} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got %b exp 00", {rf_we_en, misalign_trap}); end
    n_cmp++; if (pc_plus4 !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, RESET_PC + 32'd4); end
    rst_n = 1'b1;
    m_pc = RESET_PC; m_instret = '0; m_instr = NOP;
    @(posedge clk); #1;
    t = '{rdata: NOP, imem_wait: 0, br: 1'b0, tgt: 32'h0, dacc: 1'b0, mem_cycles: 0};
    issue(t, o);
    e = sb_q.pop_front();
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL first_instr got %h exp %h", o, e); end
  endtask

  task automatic test_branch();
    txn_t tbl[4];
    res_t o, e;
    tbl[0] = '{rdata: 32'h1000_0063, imem_wait: 0, br: 1'b1, tgt: 32'h0000_0100, dacc: 1'b0, mem_cycles: 0};
    tbl[1] = '{rdata: 32'h0000_0033, imem_wait: 2, br: 1'b0, tgt: 32'hFFFF_FFF0, dacc: 1'b0, mem_cycles: 0};
    tbl[2] = '{rdata: 32'hFE00_0EE3, imem_wait: 0, br: 1'b1, tgt: 32'h0000_0100, dacc: 1'b0, mem_cycles: 0};
    tbl[3] = '{rdata: 32'h0C00_006F, imem_wait: 1, br: 1'b1, tgt: 32'hAABB_CCDC, dacc: 1'b0, mem_cycles: 0};
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i], o);
      e = sb_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL branch[%0d] got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_jalr_misalign();
    txn_t tbl[2];
    res_t o, e;
    tbl[0] = '{rdata: 32'h0000_8067, imem_wait: 0, br: 1'b1, tgt: 32'h0000_0201, dacc: 1'b0, mem_cycles: 0};
    tbl[1] = '{rdata: 32'h0020_8067, imem_wait: 0, br: 1'b1, tgt: 32'h0000_0202, dacc: 1'b0, mem_cycles: 0};
    for (int i = 0; i < 2; i++) begin
      issue(tbl[i], o);
      e = sb_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL jalr_misalign[%0d] got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_mem_stall();
    txn_t tbl[2];
    res_t o, e;
    tbl[0] = '{rdata: 32'h0000_2083, imem_wait: 0, br: 1'b0, tgt: 32'h0, dacc: 1'b1, mem_cycles: 5};
    tbl[1] = '{rdata: 32'h0010_2023, imem_wait: 1, br: 1'b0, tgt: 32'h0, dacc: 1'b1, mem_cycles: 1};
    for (int i = 0; i < 2; i++) begin
      issue(tbl[i], o);
      e = sb_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL mem_stall[%0d] got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_hold();
    txn_t t;
    res_t o, e;
    logic [31:0] pc0;
    pc0 = pc;
    hold = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d] got %b exp 0", i, imem_req); end
      n_cmp++; if (stage !== 3'd0) begin n_bad++; $display("FAIL hold_stage[%0d] got %0d exp 0", i, stage); end
      n_cmp++; if (instr !== m_instr) begin n_bad++; $display("FAIL hold_instr[%0d] got %h exp %h", i, instr, m_instr); end
      n_cmp++; if (pc !== pc0) begin n_bad++; $display("FAIL hold_pc[%0d] got %h exp %h", i, pc, pc0); end
      @(posedge clk); #1;
    end
    hold = 1'b0; imem_valid = 1'b0;
    t = '{rdata: 32'h1234_5678, imem_wait: 0, br: 1'b0, tgt: 32'h0, dacc: 1'b0, mem_cycles: 0};
    issue(t, o);
    e = sb_q.pop_front();
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL after_hold got %h exp %h", o, e); end
  endtask

  task automatic test_reset_mid_mem();
    int unsigned we_seen = 0;
    int unsigned mem_seen = 0;
    bit reached = 0;
    for (int c = 0; c < 50; c++) begin
      imem_valid = (stage == 3'd0); imem_rdata = 32'h00A0_2003;
      dmem_access = 1'b1; dmem_done = 1'b0; branch_signal = 1'b0;
      @(negedge clk);
      if (rf_we_en) we_seen++;
      if (stage == 3'd3) mem_seen++;
      if (mem_seen == 3) begin reached = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL reach_mem got %0d MEM cycles exp 3", mem_seen); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== RESET_PC) begin n_bad++; $display("FAIL midmem_pc got %h exp %h", pc, RESET_PC); end
    n_cmp++; if (stage !== 3'd0) begin n_bad++; $display("FAIL midmem_stage got %0d exp 0", stage); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL midmem_instret got %0d exp 0", instret); end
    n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL midmem_instr got %h exp %h", instr, NOP); end
    n_cmp++; if (we_seen != 0 || rf_we_en !== 1'b0) begin n_bad++; $display("FAIL midmem_we got %0d/%b exp 0/0", we_seen, rf_we_en); end
    @(posedge clk); #1;
    n_cmp++; if (stage !== 3'd0) begin n_bad++; $display("FAIL midmem_hold_stage got %0d exp 0", stage); end
    @(negedge clk); rst_n = 1'b1; dmem_access = 1'b0; imem_valid = 1'b0;
    m_pc = RESET_PC; m_instret = '0; m_instr = NOP;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    txn_t t;
    res_t o, e;
    t = '{rdata: 32'hFFDF_F06F, imem_wait: 0, br: 1'b1, tgt: 32'hFFFF_FFFC, dacc: 1'b0, mem_cycles: 0};
    issue(t, o);
    e = sb_q.pop_front();
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wrap_jump got %h exp %h", o, e); end
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc_plus4 got %h exp 00000000", pc_plus4); end
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_imem_addr got %h exp fffffffc", imem_addr); end
    t = '{rdata: NOP, imem_wait: 0, br: 1'b0, tgt: 32'h0, dacc: 1'b0, mem_cycles: 0};
    issue(t, o);
    e = sb_q.pop_front();
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wrap_step got %h exp %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr_misalign();
    test_mem_stall();
    test_hold();
    test_reset_mid_mem();
    test_wrap();
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain got %0d left exp 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
